alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Sequencing stage that wraps the combinational 32-bit ALU on both sides.
- Upstream, it accepts commands (opcode, operands, shift, tag) over valid/ready and registers them onto the ALU input ports.
- It waits a per-opcode latency, then captures result and carry into a held response register with valid/ready toward writeback.
- It produces SNE/SLT/SEQ results locally, because the ALU does not drive them.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- SHW, 5, shift-amount width (log2 WIDTH).
- TAGW, 4, command tag width, passed through unchanged.
- MUL_LAT, 3, cycles allowed for opcode MUL (0) to settle; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command.
- cmd_opcode  in  4  ALU opcode (0..11 legal).
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_shift  in  SHW  shift/rotate amount.
- cmd_tag  in  TAGW  command tag.
- alu_opcode  out  4  to ALU opcode.
- alu_in1  out  WIDTH  to ALU input1.
- alu_in2  out  WIDTH  to ALU input2.
- alu_shift  out  SHW  to ALU shiftValue.
- alu_result  in  WIDTH  from ALU result.
- alu_carry  in  1  from ALU carryFlag.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  illegal opcode flag.
- rsp_tag  out  TAGW  tag of the command.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; cmd_ready=1; rsp_valid=0; all alu_* and rsp_* outputs = 0.
- FSM IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register opcode/a/b/shift/tag onto the alu_* outputs, load cnt = LAT-1, go to EXEC.
  - LAT = MUL_LAT for opcode 0; LAT = 1 for every other opcode.
- FSM EXEC: cmd_ready=0. alu_* outputs held stable.
  - If cnt != 0, decrement.
  - If cnt == 0, capture the response and go to DONE.
- FSM DONE: rsp_valid=1 and all rsp_* held stable. On rsp_ready, set rsp_valid=0 and go to IDLE.
  - No new command is accepted in the same cycle; cmd_ready rises in the next cycle.
- Latency: rsp_valid rises LAT rising edges after the accept edge.
  - Non-MUL: one command per 3 cycles when rsp_ready is tied high.
- Capture rules:
  - Opcodes 0 and 4..11: rsp_result=alu_result, rsp_carry=alu_carry.
  - SNE(1): {0…, a!=b}. SEQ(3): {0…, a==b}. SLT(2): {0…, $signed(a)<$signed(b)}. For all three, rsp_carry=0 and alu_result is ignored.
  - Opcodes 12..15: rsp_result=0, rsp_carry=0, rsp_err=1, LAT=1. rsp_err=0 otherwise.
- Boundary conditions:
  - cmd_valid is ignored while not in IDLE; the upstream holds it.
  - rsp_ready with rsp_valid=0 has no effect.
  - Reset mid-EXEC or mid-DONE aborts the command; no response is produced.
  - The cnt wrap is unreachable because MUL_LAT >= 1.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_cmds (32) and perf_stalls (32).
  - perf_cmds counts accepted commands.
  - perf_stalls counts cycles with rsp_valid && !rsp_ready.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams MUL..MIN (0..11);
  - state enum IDLE/EXEC/DONE;
  - the function mapping an opcode to LAT;
  - the predicate is_cmp_op(op).
- One natural sub-module: alu_issue_perf (the saturating counter pair), instantiated only under ALU_ISSUE_PERF_EN.

Test Plan:
- XOR (op 9), a=0xF0F0F0F0, b=0x0FF00FF0, tag=5, rsp_ready=1 -> rsp_valid 1 edge after accept; stub ALU returns a^b, so rsp_result=0xFF00FF00, rsp_tag=5, rsp_err=0.
- MUL (op 0), MUL_LAT=3, a=7, b=6 -> rsp_valid exactly 3 edges after accept; rsp_result=42; alu_* stable throughout EXEC.
- SLT a=0xFFFFFFFF, b=1 -> rsp_result=1, rsp_carry=0. SEQ a=b=0x1234 -> 1. SNE a=b -> 0, with the stub ALU driving 0xDEADBEEF.
- Opcode 13 -> rsp_result=0, rsp_err=1, then next command accepted normally.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready=0, rsp_* stable; under ALU_ISSUE_PERF_EN, perf_stalls=5 and perf_cmds=1.
- Assert rst_n low mid-EXEC of MUL -> all outputs 0 immediately; after release, no stale response and cmd_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and latency helpers for the ALU issue stage.
package alu_pkg;

  localparam logic [3:0] OP_MUL = 4'd0;
  localparam logic [3:0] OP_SNE = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_SEQ = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_SHF = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_MAX = 4'd10;
  localparam logic [3:0] OP_MIN = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Only MUL needs extra settle cycles; everything else, including illegal opcodes, takes one.
  function automatic logic [3:0] lat_of(input logic [3:0] op, input logic [3:0] mul_lat);
    return (op == OP_MUL) ? mul_lat : 4'd1;
  endfunction

  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op == OP_SNE) || (op == OP_SLT) || (op == OP_SEQ);
  endfunction

endpackage

// File: rtl/alu_issue_perf.sv
// Saturating accepted-command and response-stall counters for the ALU issue stage.
module alu_issue_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_perf_cmds,
  output logic [31:0] o_perf_stalls
);

  logic [31:0] r_cmds, r_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmds   <= '0;
      r_stalls <= '0;
    end else begin
      if (i_cmd_inc && (r_cmds != '1))     r_cmds   <= r_cmds + 32'd1;
      if (i_stall_inc && (r_stalls != '1)) r_stalls <= r_stalls + 32'd1;
    end
  end

  assign o_perf_cmds   = r_cmds;
  assign o_perf_stalls = r_stalls;

endmodule

// File: rtl/alu_issue_stage.sv
// Registers commands onto a combinational ALU, waits per-opcode latency, holds the response.
// Optional ALU_ISSUE_PERF_EN adds perf_cmds / perf_stalls counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHW     = 5,
  parameter int TAGW    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shift,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [SHW-1:0]   alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAGW-1:0]  rsp_tag
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_cmds,
  output logic [31:0]      perf_stalls
`endif
);

  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic [TAGW-1:0]  r_tag;
  logic             w_accept;
  logic             w_err;
  logic [WIDTH-1:0] w_cap_result;
  logic             w_cap_carry;

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);
  assign w_accept  = cmd_ready && cmd_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = EXEC;
      EXEC:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The ALU leaves the compare opcodes undriven, so they are resolved here from the latched operands.
  always_comb begin
    w_err        = alu_opcode[3] & alu_opcode[2];
    w_cap_result = alu_result;
    w_cap_carry  = alu_carry;
    if (w_err) begin
      w_cap_result = '0;
      w_cap_carry  = 1'b0;
    end else if (is_cmp_op(alu_opcode)) begin
      w_cap_carry = 1'b0;
      case (alu_opcode)
        OP_SNE:  w_cap_result = {{(WIDTH-1){1'b0}}, alu_in1 != alu_in2};
        OP_SLT:  w_cap_result = {{(WIDTH-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
        default: w_cap_result = {{(WIDTH-1){1'b0}}, alu_in1 == alu_in2};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_tag      <= '0;
      alu_opcode <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_shift  <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (w_accept) begin
        alu_opcode <= cmd_opcode;
        alu_in1    <= cmd_a;
        alu_in2    <= cmd_b;
        alu_shift  <= cmd_shift;
        r_tag      <= cmd_tag;
        r_cnt      <= lat_of(cmd_opcode, 4'(MUL_LAT)) - 4'd1;
      end else if (r_state == EXEC) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          rsp_result <= w_cap_result;
          rsp_carry  <= w_cap_carry;
          rsp_err    <= w_err;
          rsp_tag    <= r_tag;
        end
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  alu_issue_perf u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_inc     (w_accept),
    .i_stall_inc   (rsp_valid && !rsp_ready),
    .o_perf_cmds   (perf_cmds),
    .o_perf_stalls (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU stub.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [4:0]  cmd_shift;
  logic [3:0]  cmd_tag;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_shift;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_err;
  logic [3:0]  rsp_tag;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_cmds, perf_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(32), .SHW(5), .TAGW(4), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_cmds(perf_cmds), .perf_stalls(perf_stalls)
`endif
  );

  // Stub ALU: compare opcodes get junk so the stage must override it.
  always_comb begin
    alu_result = 32'hDEADBEEF;
    alu_carry  = 1'b1;
    case (alu_opcode)
      4'd0: begin alu_result = alu_in1 * alu_in2; alu_carry = 1'b0; end
      4'd4: {alu_carry, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'd9: begin alu_result = alu_in1 ^ alu_in2; alu_carry = 1'b0; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command with rsp_ready high and check latency, response and return to IDLE.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t, input int exp_lat,
                         input logic [31:0] exp_res, input logic exp_c, input logic exp_e);
    int n;
    @(negedge clk);
    rsp_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = 5'd3; cmd_tag = t;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = ~a;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
      chk({tag, "_hold_op"}, {28'd0, alu_opcode}, {28'd0, op});
      chk({tag, "_hold_in1"}, alu_in1, a);
      chk({tag, "_rdy_lo"}, {31'd0, cmd_ready}, 32'd0);
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_res"}, rsp_result, exp_res);
    chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, exp_c});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    chk({tag, "_tag"}, {28'd0, rsp_tag}, {28'd0, t});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
    #12;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_cmd("xor", 4'd9, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd5, 1, 32'hFF00FF00, 1'b0, 1'b0);
    run_cmd("mul", 4'd0, 32'd7, 32'd6, 4'd2, 3, 32'd42, 1'b0, 1'b0);
    run_cmd("slt", 4'd2, 32'hFFFFFFFF, 32'd1, 4'd3, 1, 32'd1, 1'b0, 1'b0);
    run_cmd("slt_f", 4'd2, 32'd1, 32'hFFFFFFFF, 4'd3, 1, 32'd0, 1'b0, 1'b0);
    run_cmd("seq", 4'd3, 32'h1234, 32'h1234, 4'd4, 1, 32'd1, 1'b0, 1'b0);
    run_cmd("sne", 4'd1, 32'h1234, 32'h1234, 4'd6, 1, 32'd0, 1'b0, 1'b0);
    run_cmd("sne_t", 4'd1, 32'h1234, 32'h1235, 4'd6, 1, 32'd1, 1'b0, 1'b0);
    run_cmd("ill", 4'd13, 32'd5, 32'd6, 4'd7, 1, 32'd0, 1'b0, 1'b1);
    run_cmd("add", 4'd4, 32'hFFFFFFFF, 32'd1, 4'd8, 1, 32'd0, 1'b1, 1'b0);

    // Reset in the middle of a MUL.
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    cmd_opcode = 4'd0; cmd_a = 32'd3; cmd_b = 32'd9; cmd_tag = 4'd9;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst_mid_op", {28'd0, alu_opcode}, 32'd0);
    chk("rst_mid_in1", alu_in1, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_tag", {28'd0, rsp_tag}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", {31'd0, rsp_valid}, 32'd0);
    end
    chk("rst_after_rdy", {31'd0, cmd_ready}, 32'd1);

    // Backpressure: hold rsp_ready low in DONE while upstream keeps presenting a command.
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b1;
    cmd_opcode = 4'd9; cmd_a = 32'd1; cmd_b = 32'd3; cmd_tag = 4'd1;
    @(posedge clk); #1;
    cmd_opcode = 4'd4; cmd_a = 32'd100; cmd_tag = 4'd2;
    @(posedge clk); #1;
    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    held = rsp_result;
    chk("bp_res", held, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rdy_lo", {31'd0, cmd_ready}, 32'd0);
      chk("bp_stable", {27'd0, rsp_valid, rsp_tag}, {27'd0, 1'b1, 4'd1});
      chk("bp_res_hold", rsp_result, 32'd2);
    end
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_stalls", perf_stalls, 32'd5);
    chk("perf_cmds", perf_cmds, 32'd1);
`endif
    @(negedge clk); cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
